// File: rtl/stream_token_fifo.sv
// First-word-fall-through FIFO carrying payload words and close tokens.
// The top bit of each word marks a close (end-of-transfer) token; the block
// counts stored words and stored close tokens, and keeps sticky error flags
// for writes while full and reads while empty.
module stream_token_fifo #(
    parameter int DATA_WIDTH = 33,
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = 2
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic [DATA_WIDTH-1:0] s_din,
    input  logic                  s_write,
    output logic                  s_full_n,
    output logic [DATA_WIDTH-1:0] s_dout,
    output logic [DATA_WIDTH-1:0] s_peek,
    output logic                  s_empty_n,
    input  logic                  s_read,
    output logic [ADDR_WIDTH:0]   occupancy,
    output logic [ADDR_WIDTH:0]   close_pending,
    output logic                  err_overflow,
    output logic                  err_underflow
);

    localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = 1;
    localparam logic [ADDR_WIDTH:0]   CNT_ONE   = 1;
    localparam logic [ADDR_WIDTH:0]   DEPTH_CNT = (ADDR_WIDTH+1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   occ;
    logic [ADDR_WIDTH:0]   occ_next;
    logic [ADDR_WIDTH:0]   cp;
    logic [ADDR_WIDTH:0]   cp_next;
    logic                  full_n_q;
    logic                  empty_n_q;
    logic                  ovf;
    logic                  unf;
    logic                  wr_acc;
    logic                  rd_acc;
    logic                  close_in;
    logic                  close_out;
    logic [DATA_WIDTH-1:0] head;

    // Handshake qualification uses the registered flags, so a full FIFO never
    // takes a write even when a read frees an entry on the same edge.
    assign wr_acc    = s_write & full_n_q;
    assign rd_acc    = s_read & empty_n_q;
    assign head      = empty_n_q ? mem[rd_ptr] : '0;
    assign close_in  = s_din[DATA_WIDTH-1];
    assign close_out = head[DATA_WIDTH-1];

    assign s_dout        = head;
    assign s_peek        = head;
    assign s_full_n      = full_n_q;
    assign s_empty_n     = empty_n_q;
    assign occupancy     = occ;
    assign close_pending = cp;
    assign err_overflow  = ovf;
    assign err_underflow = unf;

    // Next-state word and close-token counts from the accepted operations.
    always_comb begin
        occ_next = occ;
        cp_next  = cp;
        if (wr_acc && !rd_acc) begin
            occ_next = occ + CNT_ONE;
        end else if (rd_acc && !wr_acc) begin
            occ_next = occ - CNT_ONE;
        end
        if ((wr_acc && close_in) && !(rd_acc && close_out)) begin
            cp_next = cp + CNT_ONE;
        end else if ((rd_acc && close_out) && !(wr_acc && close_in)) begin
            cp_next = cp - CNT_ONE;
        end
    end

    // Storage array; contents survive reset since the pointers and flags
    // already hide any stale words.
    always_ff @(posedge ap_clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= s_din;
        end
    end

    // Pointers, counters, registered full/empty flags and sticky errors.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occ       <= '0;
            cp        <= '0;
            full_n_q  <= 1'b0;
            empty_n_q <= 1'b0;
            ovf       <= 1'b0;
            unf       <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            occ       <= occ_next;
            cp        <= cp_next;
            full_n_q  <= (occ_next != DEPTH_CNT);
            empty_n_q <= (occ_next != '0);
            if (s_write && !full_n_q) begin
                ovf <= 1'b1;
            end
            if (s_read && !empty_n_q) begin
                unf <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_stream_token_fifo.sv
// Directed bench for stream_token_fifo: expected words are queued when a
// write is issued, and a monitor pops and compares whenever a read is taken.
module tb_stream_token_fifo;

    localparam int DW = 33;
    localparam int AW = 2;

    logic          ap_clk = 1'b0;
    logic          ap_rst_n = 1'b0;
    logic [DW-1:0] s_din = '0;
    logic          s_write = 1'b0;
    logic          s_full_n;
    logic [DW-1:0] s_dout;
    logic [DW-1:0] s_peek;
    logic          s_empty_n;
    logic          s_read = 1'b0;
    logic [AW:0]   occupancy;
    logic [AW:0]   close_pending;
    logic          err_overflow;
    logic          err_underflow;

    int vectors = 0;
    int miscompares = 0;
    logic [DW-1:0] exp_q [$];

    stream_token_fifo #(.DATA_WIDTH(DW), .DEPTH(4), .ADDR_WIDTH(AW)) dut (
        .ap_clk        (ap_clk),
        .ap_rst_n      (ap_rst_n),
        .s_din         (s_din),
        .s_write       (s_write),
        .s_full_n      (s_full_n),
        .s_dout        (s_dout),
        .s_peek        (s_peek),
        .s_empty_n     (s_empty_n),
        .s_read        (s_read),
        .occupancy     (occupancy),
        .close_pending (close_pending),
        .err_overflow  (err_overflow),
        .err_underflow (err_underflow)
    );

    always #5 ap_clk = ~ap_clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock with the given inputs; inputs drop again just after the edge.
    task automatic cyc(input logic w, input logic [DW-1:0] d, input logic r);
        s_write = w;
        s_din   = d;
        s_read  = r;
        @(posedge ap_clk);
        #1;
        s_write = 1'b0;
        s_read  = 1'b0;
        s_din   = '0;
    endtask

    task automatic wr(input logic [DW-1:0] d);
        exp_q.push_back(d);
        cyc(1'b1, d, 1'b0);
    endtask

    task automatic rd();
        cyc(1'b0, '0, 1'b1);
    endtask

    // Monitor: a read that will be accepted on the coming edge must show the
    // oldest outstanding expected word on both dout and peek.
    always @(negedge ap_clk) begin
        if (ap_rst_n && s_read && s_empty_n) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL pop_unexpected: got 0x%0h, expected no word", s_dout);
            end else begin
                logic [DW-1:0] e;
                e = exp_q.pop_front();
                check("dout", 64'(s_dout), 64'(e));
                check("peek", 64'(s_peek), 64'(e));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #1;
        check("rst_full_n", 64'(s_full_n), 0);
        check("rst_empty_n", 64'(s_empty_n), 0);
        check("rst_dout", 64'(s_dout), 0);
        check("rst_occ", 64'(occupancy), 0);
        check("rst_cp", 64'(close_pending), 0);
        check("rst_errs", 64'({err_overflow, err_underflow}), 0);
        @(posedge ap_clk);
        #2 ap_rst_n = 1'b1;
        #1 check("pre_edge_full_n", 64'(s_full_n), 0);
        @(posedge ap_clk);
        #1;
        check("post_rel_full_n", 64'(s_full_n), 1);
        check("post_rel_occ", 64'(occupancy), 0);

        // Fill and drain
        wr(33'h1); wr(33'h2); wr(33'h3);
        check("fill3_full_n", 64'(s_full_n), 1);
        wr(33'h4);
        check("fill_full_n", 64'(s_full_n), 0);
        check("fill_occ", 64'(occupancy), 4);
        check("fill_empty_n", 64'(s_empty_n), 1);
        rd(); rd(); rd(); rd();
        check("drain_empty_n", 64'(s_empty_n), 0);
        check("drain_occ", 64'(occupancy), 0);
        check("drain_dout", 64'(s_dout), 0);

        // Close token
        wr({1'b0, 32'h3F80_0000});
        wr({1'b1, 32'h0});
        check("close_cp2", 64'(close_pending), 1);
        check("close_occ", 64'(occupancy), 2);
        rd();
        check("close_cp1", 64'(close_pending), 1);
        rd();
        check("close_cp0", 64'(close_pending), 0);
        check("close_empty_n", 64'(s_empty_n), 0);

        // Overflow: full, write and read on the same edge
        wr(33'h5); wr(33'h6); wr(33'h7); wr(33'h8);
        check("ovf_pre_err", 64'(err_overflow), 0);
        cyc(1'b1, 33'h9, 1'b1);
        check("ovf_err", 64'(err_overflow), 1);
        check("ovf_occ", 64'(occupancy), 3);
        check("ovf_full_n", 64'(s_full_n), 1);
        rd(); rd(); rd();
        check("ovf_drain_occ", 64'(occupancy), 0);
        check("ovf_sticky", 64'(err_overflow), 1);

        // Underflow: empty, write and read on the same edge
        check("unf_pre_err", 64'(err_underflow), 0);
        exp_q.push_back(33'hA);
        cyc(1'b1, 33'hA, 1'b1);
        check("unf_occ", 64'(occupancy), 1);
        check("unf_dout", 64'(s_dout), 33'hA);
        check("unf_err", 64'(err_underflow), 1);

        // Streaming across pointer wrap with one word prefilled
        for (int i = 0; i < 10; i++) begin
            exp_q.push_back(DW'(i));
            cyc(1'b1, DW'(i), 1'b1);
            check("stream_occ", 64'(occupancy), 1);
        end
        rd();
        check("stream_end_occ", 64'(occupancy), 0);
        check("stream_q_empty", 64'(exp_q.size()), 0);

        // Mid-operation reset with three words stored
        wr(33'h11); wr({1'b1, 32'h22}); wr(33'h33);
        check("mr_occ", 64'(occupancy), 3);
        check("mr_cp", 64'(close_pending), 1);
        #2 ap_rst_n = 1'b0;
        #1;
        exp_q.delete();
        check("mr_full_n", 64'(s_full_n), 0);
        check("mr_empty_n", 64'(s_empty_n), 0);
        check("mr_dout", 64'(s_dout), 0);
        check("mr_peek", 64'(s_peek), 0);
        check("mr_occ0", 64'(occupancy), 0);
        check("mr_cp0", 64'(close_pending), 0);
        check("mr_errs", 64'({err_overflow, err_underflow}), 0);
        #2 ap_rst_n = 1'b1;
        #1 check("mr_rel_full_n", 64'(s_full_n), 0);
        @(posedge ap_clk);
        #1;
        check("mr_edge_full_n", 64'(s_full_n), 1);
        check("mr_edge_empty_n", 64'(s_empty_n), 0);
        wr(33'h55);
        check("mr_after_occ", 64'(occupancy), 1);
        rd();
        check("mr_final_occ", 64'(occupancy), 0);
        check("final_q_empty", 64'(exp_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/stream_token_fifo.md
STREAM_TOKEN_FIFO -- requirements
Module: stream_token_fifo

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 33, meaning the FIFO word width: bit DATA_WIDTH-1 is the close (end-of-transfer) token flag and bits DATA_WIDTH-2:0 are payload.
REQ-002 The block SHALL have parameter DEPTH, default 4, meaning the number of storage entries; DEPTH is a power of two and at least 2.
REQ-003 The block SHALL have parameter ADDR_WIDTH, default 2, equal to log2(DEPTH).
REQ-004 Port ap_clk, input, 1 bit: the single clock; all state changes on its rising edge except reset.
REQ-005 Port ap_rst_n, input, 1 bit: reset, asynchronous assertion, active-low.
REQ-006 Port s_din, input, DATA_WIDTH bits: write data from the producer.
REQ-007 Port s_write, input, 1 bit: producer write request.
REQ-008 Port s_full_n, output, 1 bit: high when the FIFO can accept a word.
REQ-009 Port s_dout, output, DATA_WIDTH bits: head-of-FIFO data to the consumer.
REQ-010 Port s_peek, output, DATA_WIDTH bits: same value as s_dout, for non-consuming inspection.
REQ-011 Port s_empty_n, output, 1 bit: high when s_dout holds a valid word.
REQ-012 Port s_read, input, 1 bit: consumer read (pop) request.
REQ-013 Port occupancy, output, ADDR_WIDTH+1 bits: number of words stored, 0..DEPTH.
REQ-014 Port close_pending, output, ADDR_WIDTH+1 bits: number of stored words with the close flag set.
REQ-015 Port err_overflow, output, 1 bit: sticky flag, set by a write attempted while s_full_n=0.
REQ-016 Port err_underflow, output, 1 bit: sticky flag, set by a read attempted while s_empty_n=0.

Function
REQ-017 The FIFO SHALL be first-word-fall-through: s_dout = s_peek = mem[rd_ptr] when s_empty_n=1, and all zeros when s_empty_n=0.
REQ-018 A write SHALL be accepted on a rising edge exactly when s_write=1 and s_full_n=1; s_din is stored at wr_ptr and wr_ptr increments modulo DEPTH.
REQ-019 A read SHALL be accepted on a rising edge exactly when s_read=1 and s_empty_n=1; rd_ptr increments modulo DEPTH.
REQ-020 A read and a write SHALL be accepted on the same edge when both qualify; occupancy is then unchanged.
REQ-021 When full, s_full_n=0 and a same-cycle read SHALL NOT make room for a same-cycle write; the write is rejected and err_overflow is set.
REQ-022 When empty, a same-cycle write SHALL be accepted, the read SHALL be rejected, and err_underflow is set.
REQ-023 s_full_n and s_empty_n SHALL be registered and computed from the next-state occupancy: s_full_n = (next occupancy != DEPTH), s_empty_n = (next occupancy != 0).
REQ-024 Write-to-read latency SHALL be 1 cycle: a word written at edge t is presented with s_empty_n=1 after edge t.
REQ-025 occupancy SHALL increment on an accepted write only, decrement on an accepted read only, and be unchanged on both or neither.
REQ-026 close_pending SHALL increment on an accepted write with s_din[DATA_WIDTH-1]=1, decrement on an accepted read with s_dout[DATA_WIDTH-1]=1, and apply the net change on simultaneous events.
REQ-027 The close flag SHALL be stored and forwarded unmodified; close tokens occupy one entry like any other word.
REQ-028 err_overflow and err_underflow SHALL remain set until reset; rejected operations SHALL NOT alter pointers, memory, or counters.
REQ-029 Pointer wrap from DEPTH-1 to 0 SHALL be seamless, with no bubble or lost word.

Reset
REQ-030 While ap_rst_n=0, the outputs SHALL be: s_full_n=0, s_empty_n=0, s_dout=s_peek=0, occupancy=0, close_pending=0, err_overflow=0, err_underflow=0; both pointers are 0.
REQ-031 s_full_n SHALL rise at the first rising edge after ap_rst_n deasserts; no write is accepted during that edge.
REQ-032 Reset asserted mid-operation SHALL discard all stored words immediately, asynchronously; memory contents need not be cleared.

Verification
REQ-033 Fill/drain: write payloads 0x1,0x2,0x3,0x4 with no reads -> s_full_n=0 and occupancy=4 after the 4th edge; read 4 times -> s_dout is 0x1..0x4 in order, then s_empty_n=0 and occupancy=0.
REQ-034 Close token: write {1'b0,3F800000}, then {1'b1,0} -> close_pending=1; reading both returns the same bits and ends with close_pending=0.
REQ-035 Overflow: with the FIFO full, hold s_write=1 and s_read=1 for one edge -> one word is popped, the write is rejected, err_overflow=1, occupancy=3.
REQ-036 Underflow: with the FIFO empty, s_write=1 (0xA) and s_read=1 on the same edge -> occupancy=1, s_dout=0xA, err_underflow=1.
REQ-037 Streaming wrap: write and read every cycle for 10 words 0..9 after one prefill -> output order is intact across pointer wrap, and occupancy stays at 1.
REQ-038 Mid-operation reset: with 3 words stored, pulse ap_rst_n low between edges -> all outputs take their REQ-030 values immediately, and s_full_n=1 only after the first edge following release.
